// File: rtl/alu_ctrl_pkg.sv
// Shared types for the ALU command controller: opcodes, FSM states, latency helper.
package alu_ctrl_pkg;

    localparam int CNT_W   = 8;
    localparam int NUM_OPS = 13;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,  OP_SUB = 4'd1,  OP_CMP = 4'd2,  OP_MUL = 4'd3,
        OP_DIV = 4'd4,  OP_MOD = 4'd5,  OP_LSL = 4'd6,  OP_LSR = 4'd7,
        OP_ASR = 4'd8,  OP_OR  = 4'd9,  OP_NOT = 4'd10, OP_AND = 4'd11,
        OP_MOV = 4'd12
    } op_e;

    typedef enum logic [2:0] {
        ST_INIT, ST_IDLE, ST_LOAD, ST_EXEC, ST_CAPT, ST_RESP
    } state_e;

    // Number of EXEC cycles the select is held before capture.
    function automatic logic [CNT_W-1:0] op_lat(input logic [3:0] op,
                                                input int unsigned mul_lat,
                                                input int unsigned div_lat);
        case (op)
            OP_MUL:         return CNT_W'(mul_lat);
            OP_DIV, OP_MOD: return CNT_W'(div_lat);
            default:        return CNT_W'(1);
        endcase
    endfunction

endpackage

// File: rtl/alu_ctrl_op_decode.sv
// Combinational opcode decode: 4-bit op to one-hot ALU select plus legality.
module alu_op_decode
    import alu_ctrl_pkg::*;
(
    input  logic [3:0]         op,
    output logic [NUM_OPS-1:0] sel,
    output logic               legal
);

    always_comb begin
        sel   = '0;
        legal = (op < 4'(NUM_OPS));
        if (legal) sel[op] = 1'b1;
    end

endmodule

// File: rtl/alu_ctrl.sv
// Sequences load/execute/capture on a register-wrapped ALU for one command at a time.
// Optional ALU_CTRL_DIV0_TRAP_EN rejects DIV/MOD by zero as an illegal command.
module alu_ctrl
    import alu_ctrl_pkg::*;
#(
    parameter int unsigned MUL_LAT = 1,
    parameter int unsigned DIV_LAT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [3:0]  cmd_op,
    input  logic [31:0] cmd_a,
    input  logic [31:0] cmd_b,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_err,
    output logic        ldA,
    output logic        ldB,
    output logic        ldResult,
    output logic        clrA,
    output logic        clrB,
    output logic        clrResult,
    output logic        isAdd,
    output logic        isSub,
    output logic        isCmp,
    output logic        isMul,
    output logic        isDiv,
    output logic        isMod,
    output logic        isLsl,
    output logic        isLsr,
    output logic        isAsr,
    output logic        isOr,
    output logic        isNot,
    output logic        isAnd,
    output logic        isMov,
    output logic [31:0] AIn,
    output logic [31:0] BIn,
    input  logic [31:0] aluResult,
    input  logic        Eq,
    input  logic        Gt,
    output logic        flagWr
);

    state_e             state_q, state_d;
    logic [3:0]         op_q, op_d;
    logic [NUM_OPS-1:0] sel_q, sel_d, dec_sel, is_vec;
    logic [31:0]        a_q, a_d, b_q, b_d, rsp_data_q, rsp_data_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               rsp_err_q, rsp_err_d, arm_q, arm_d;
    logic               dec_legal, div0, active, is_cmp;

    alu_op_decode u_dec (.op(cmd_op), .sel(dec_sel), .legal(dec_legal));

`ifdef ALU_CTRL_DIV0_TRAP_EN
    assign div0 = ((cmd_op == OP_DIV) || (cmd_op == OP_MOD)) && (cmd_b == 32'd0);
`else
    assign div0 = 1'b0;
`endif

    assign arm_d  = 1'b1;
    assign is_cmp = (op_q == OP_CMP);

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        sel_d      = sel_q;
        a_d        = a_q;
        b_d        = b_q;
        cnt_d      = cnt_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        case (state_q)
            // arm_q delays the clear pulse to the first full cycle out of reset
            ST_INIT: if (arm_q) state_d = ST_IDLE;
            ST_IDLE: begin
                if (cmd_valid) begin
                    op_d = cmd_op;
                    a_d  = cmd_a;
                    b_d  = cmd_b;
                    if (dec_legal && !div0) begin
                        sel_d   = dec_sel;
                        state_d = ST_LOAD;
                    end else begin
                        sel_d      = '0;
                        rsp_data_d = 32'd0;
                        rsp_err_d  = 1'b1;
                        state_d    = ST_RESP;
                    end
                end
            end
            ST_LOAD: begin
                cnt_d   = op_lat(op_q, MUL_LAT, DIV_LAT);
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q <= CNT_W'(1)) state_d = ST_CAPT;
            end
            ST_CAPT: begin
                rsp_data_d = is_cmp ? {30'b0, Gt, Eq} : aluResult;
                rsp_err_d  = 1'b0;
                state_d    = ST_RESP;
            end
            ST_RESP: if (rsp_ready) state_d = ST_IDLE;
            default: state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_INIT;
            op_q       <= '0;
            sel_q      <= '0;
            a_q        <= '0;
            b_q        <= '0;
            cnt_q      <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
            arm_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            sel_q      <= sel_d;
            a_q        <= a_d;
            b_q        <= b_d;
            cnt_q      <= cnt_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
            arm_q      <= arm_d;
        end
    end

    assign active    = (state_q == ST_EXEC) || (state_q == ST_CAPT);
    assign is_vec    = active ? sel_q : '0;
    assign cmd_ready = (state_q == ST_IDLE);
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign AIn       = a_q;
    assign BIn       = b_q;
    assign ldA       = (state_q == ST_LOAD);
    assign ldB       = (state_q == ST_LOAD);
    assign ldResult  = (state_q == ST_CAPT) && !is_cmp;
    assign flagWr    = (state_q == ST_CAPT) && is_cmp;
    assign clrA      = (state_q == ST_INIT) && arm_q;
    assign clrB      = clrA;
    assign clrResult = clrA;

    assign isAdd = is_vec[OP_ADD];
    assign isSub = is_vec[OP_SUB];
    assign isCmp = is_vec[OP_CMP];
    assign isMul = is_vec[OP_MUL];
    assign isDiv = is_vec[OP_DIV];
    assign isMod = is_vec[OP_MOD];
    assign isLsl = is_vec[OP_LSL];
    assign isLsr = is_vec[OP_LSR];
    assign isAsr = is_vec[OP_ASR];
    assign isOr  = is_vec[OP_OR];
    assign isNot = is_vec[OP_NOT];
    assign isAnd = is_vec[OP_AND];
    assign isMov = is_vec[OP_MOV];

endmodule
